// File: rtl/sqrt_periph_param.sv
// Memory-mapped integer square-root peripheral (digit-by-digit engine, WIDTH-bit operand).
// Latency: WIDTH/2 cycles from accepted start to ROOT/REM/done; register reads return 1 cycle after the strobe.
// Backpressure: none; a start while busy is dropped and flags overrun. Optional irq via SQRT_PERIPH_IRQ_EN.
module sqrt_periph_param #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);

    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(HW + 1);

    localparam logic [4:0] ADDR_CTRL = 5'h00;
    localparam logic [4:0] ADDR_A    = 5'h04;
    localparam logic [4:0] ADDR_STAT = 5'h08;
    localparam logic [4:0] ADDR_ROOT = 5'h0C;
    localparam logic [4:0] ADDR_REM  = 5'h10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] op_q;
    logic [HW-1:0]    root_part_q;
    logic [HW:0]      rem_part_q;
    logic [CW-1:0]    cnt_q;
    logic [HW-1:0]    root_q;
    logic [HW:0]      rem_q;
    logic             done_q, overrun_q;
    logic             irq_en_q;

    // Upper write-data bits beyond the operand (and CTRL bit1 without irq support) are don't-care.
    logic unused_dat;
    assign unused_dat = ^d_in;

    // Bus decode
    logic wr_ctrl, wr_a, wr_stat, rd_en;
    logic start_req, start_ok, finish;
    assign wr_ctrl   = cs && wr && (addr == ADDR_CTRL);
    assign wr_a      = cs && wr && (addr == ADDR_A);
    assign wr_stat   = cs && wr && (addr == ADDR_STAT);
    assign rd_en     = cs && rd;
    assign start_req = wr_ctrl && d_in[0];
    assign start_ok  = start_req && (state_q == IDLE);
    assign finish    = (state_q == RUN) && (cnt_q == CW'(1));

    // One root digit per cycle: bring down two operand bits, trial-subtract (root<<2)|1.
    logic [HW+2:0] cand, sub, diff;
    logic          take;
    logic [HW:0]   rem_nx;
    logic [HW-1:0] root_nx;
    always_comb begin
        cand    = {rem_part_q, op_q[WIDTH-1 -: 2]};
        sub     = {1'b0, root_part_q, 2'b01};
        diff    = cand - sub;
        take    = (cand >= sub);
        rem_nx  = take ? diff[HW:0] : cand[HW:0];
        root_nx = {root_part_q[HW-2:0], take};
    end

    // Next values of the status flags; completion beats a same-cycle clear.
    logic done_d, overrun_d, irq_en_d;
    always_comb begin
        done_d = done_q;
        if (finish)
            done_d = 1'b1;
        else if (start_ok || (wr_stat && d_in[1]))
            done_d = 1'b0;

        overrun_d = overrun_q;
        if (start_req && (state_q == RUN))
            overrun_d = 1'b1;
        else if (wr_stat && d_in[2])
            overrun_d = 1'b0;

`ifdef SQRT_PERIPH_IRQ_EN
        irq_en_d = wr_ctrl ? d_in[1] : irq_en_q;
`else
        irq_en_d = 1'b0;
`endif
    end

    // FSM next state: IDLE waits for start, RUN counts down the digit iterations.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (finish)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Engine datapath: snapshot on start, iterate while running, publish result on the last digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            root_part_q <= '0;
            rem_part_q  <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
        end else if (start_ok) begin
            op_q        <= a_q;
            root_part_q <= '0;
            rem_part_q  <= '0;
            cnt_q       <= CW'(HW);
        end else if (state_q == RUN) begin
            op_q        <= {op_q[WIDTH-3:0], 2'b00};
            root_part_q <= root_nx;
            rem_part_q  <= rem_nx;
            cnt_q       <= cnt_q - CW'(1);
            if (finish) begin
                root_q <= root_nx;
                rem_q  <= rem_nx;
            end
        end
    end

    // Software-visible registers and the registered interrupt line.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_a) a_q <= d_in[WIDTH-1:0];
            done_q    <= done_d;
            overrun_q <= overrun_d;
            irq       <= done_d && irq_en_d;
        end
    end

`ifdef SQRT_PERIPH_IRQ_EN
    // Interrupt enable bit, written through CTRL bit1.
    always_ff @(posedge clk) begin
        if (reset) irq_en_q <= 1'b0;
        else       irq_en_q <= irq_en_d;
    end
`else
    assign irq_en_q = 1'b0;
`endif

    // Read mux, zero-extended to the bus width.
    logic [31:0] rdata;
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL: rdata[1]       = irq_en_q;
            ADDR_A:    rdata[WIDTH-1:0] = a_q;
            ADDR_STAT: rdata[2:0]     = {overrun_q, done_q, (state_q == RUN)};
            ADDR_ROOT: rdata[HW-1:0]  = root_q;
            ADDR_REM:  rdata[HW:0]    = rem_q;
            default:   rdata = '0;
        endcase
    end

    // Read data register: captures on a read strobe, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset)      d_out <= '0;
        else if (rd_en) d_out <= rdata;
    end

endmodule

// File: doc/sqrt_periph_param.md
# sqrt_periph_param

Parametrised memory-mapped integer square-root peripheral for the processor's peripheral bus. It contains its own digit-by-digit square-root engine of configurable operand width and returns root and remainder. It also provides a busy/done/overrun status register and an optional completion interrupt. It sits behind the address decoder like the other arithmetic peripherals, selected by `cs` with a 5-bit word-aligned offset.

## Interface
- `WIDTH`, 32, operand width in bits; even, 4..32; root is WIDTH/2 bits, remainder WIDTH/2+1 bits
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `d_in`  in  32  write data; bits above the used field ignored
- `cs`  in  1  peripheral select
- `addr`  in  5  byte offset: 0x00 CTRL, 0x04 A, 0x08 STATUS, 0x0C ROOT, 0x10 REM
- `rd`  in  1  read strobe, qualified by cs
- `wr`  in  1  write strobe, qualified by cs
- `d_out`  out  32  registered read data, zero-extended
- `irq`  out  1  level interrupt = done & irq_en (see Configuration)

## Operation
- CTRL write:
  - bit0 = start, self-clearing pulse, not stored.
  - bit1 = irq_en, stored.
  - CTRL read returns {30'b0, irq_en, 1'b0}.
- A: WIDTH-bit read/write operand register. Writes are accepted at any time. A running computation uses a snapshot taken at start.
- STATUS bits:
  - bit0 busy.
  - bit1 done, sticky.
  - bit2 overrun, sticky.
  - Writing 1 to bit1 or bit2 clears that bit; other bits are read-only.
- ROOT = floor(sqrt(A_snapshot)). REM = A_snapshot − ROOT². Both hold until the next completion.
- FSM states IDLE, RUN:
  - IDLE + start: snapshot A into the shift register, clear partial root and remainder, load counter = WIDTH/2, busy=1, clear done → RUN.
  - RUN: each cycle, shift 2 operand MSBs into the remainder and trial-subtract (root<<2)|1. If the result is non-negative, keep it and shift in root bit 1; otherwise shift in 0. Decrement the counter.
  - RUN with counter reaching 0: write ROOT/REM, busy=0, done=1 → IDLE.
- Start while busy: ignored, computation undisturbed, overrun set to 1. The irq_en bit of the same write is still applied.
- Done set and a done-clear write in the same cycle: set wins, done stays 1.
- Writes to unmapped offsets: no effect. Reads of unmapped offsets: 0.
- Reset values:
  - A=0, irq_en=0, busy=0, done=0, overrun=0.
  - ROOT=0, REM=0, d_out=0, irq=0, state IDLE.
- Reset mid-computation aborts immediately. No result is written and done stays 0.

## Timing
- Write takes effect at the rising edge where cs & wr are high.
- Start accepted at edge N → busy reads 1 from edge N.
- Iterations run on edges N+1 .. N+WIDTH/2. At edge N+WIDTH/2, ROOT, REM and done are valid and busy=0. Latency is WIDTH/2 cycles, 16 for WIDTH=32.
- Back-to-back: a start written at edge N+WIDTH/2+1 is accepted normally.
- Read: d_out is captured at the rising edge with cs & rd and is valid after that edge. It holds its value when not reading. Read latency is 1 cycle.
- irq is registered and asserts on the same edge as done.
- rd and wr asserted together: both are performed; the read returns the pre-write value.

## Configuration
- `SQRT_PERIPH_IRQ_EN` defined:
  - irq_en bit exists in CTRL.
  - irq = done & irq_en; it deasserts on the edge after done is cleared or irq_en is cleared.
- Undefined:
  - CTRL bit1 is write-ignored and reads 0.
  - irq is tied to 0.
  - The register map and all other behaviour are unchanged.

## Test plan
- WIDTH=32, write A=144, start → busy=1 for 16 cycles, then ROOT=12, REM=0, STATUS=0x2.
- A=0xFFFFFFFF → ROOT=0xFFFF, REM=0x1FFFE; A=0 → ROOT=0, REM=0; A=2 → ROOT=1, REM=1.
- Start at edge N, second start at N+5 with A rewritten to 9 → result for the original A, overrun=1. Write 0x4 to STATUS → overrun=0.
- Macro defined, irq_en=1, A=1000 → irq rises with done, ROOT=31, REM=39. Write 0x2 to STATUS → irq=0 one edge later. Macro undefined → irq stays 0.
- Assert reset at edge N+7 of a run → busy=0, done=0, ROOT=0, d_out=0. A new start after reset computes correctly.
- WIDTH=8, A=0xFF → ROOT=15, REM=30 after 4 cycles. Read unmapped offset 0x14 → d_out=0.
